// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
package divider_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Iteration counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, try to subtract.
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;

    // The shifted remainder can reach 2*|B|-1, so the trial needs a sign bit
    // on top of the WIDTH+1-bit shifted value; a kept remainder is < |B|.
    assign w_shift = {i_rem, i_bit};
    assign w_trial = {1'b0, w_shift} - {2'b00, i_dvs};
    assign o_qbit  = ~w_trial[WIDTH+1];
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one quotient bit per clock, fixed latency.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;   // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sa;
    logic             r_sb;
    logic             r_dz;
    logic             r_ov;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_next_rem;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_qbit;

    // Magnitudes are kept unsigned, so |most negative| = 2^(WIDTH-1) fits
    // without loss; negating the most negative value yields that pattern.
    assign w_abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // Sign fix-up: quotient follows sign(A)^sign(B), remainder follows sign(A).
    // With B=0 every trial succeeds, so r_rem ends up as |A| and the fix-up
    // restores A itself for the remainder.
    assign w_q_fix = (r_sa ^ r_sb) ? -r_quo : r_quo;
    assign w_r_fix = r_sa ? -r_rem : r_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_dvs  (r_dvs),
        .i_bit  (r_quo[WIDTH-1]),
        .o_rem  (w_next_rem),
        .o_qbit (w_qbit)
    );

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_dvs          <= '0;
            r_sa           <= 1'b0;
            r_sb           <= 1'b0;
            r_dz           <= 1'b0;
            r_ov           <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (ctrl_DIV) begin
                // A new start abandons whatever was in flight.
                r_state <= S_BUSY;
                r_cnt   <= CW'(WIDTH);
                r_quo   <= w_abs_a;
                r_rem   <= '0;
                r_dvs   <= w_abs_b;
                r_sa    <= data_operandA[WIDTH-1];
                r_sb    <= data_operandB[WIDTH-1];
                r_dz    <= (data_operandB == '0);
                r_ov    <= (data_operandA == MIN_VAL) && (data_operandB == '1);
                busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_BUSY: begin
                        r_rem <= w_next_rem;
                        r_quo <= {r_quo[WIDTH-2:0], w_qbit};
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                        end
                    end
                    S_DONE: begin
                        // Overflow needs no override: |MIN|/1 = 2^(WIDTH-1)
                        // reads back as MIN, remainder 0.
                        data_result    <= r_dz ? '0 : w_q_fix;
                        data_remainder <= w_r_fix;
                        data_exception <= r_dz | r_ov;
                        data_resultRDY <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a reference model.
module tb_seq_divider;

    localparam int W       = 32;
    localparam int LAT     = W + 1;
    localparam int TIMEOUT = 200;

    logic         clock;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   x;
        longint la;
        longint lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == '0) begin
            x.q = '0;
            x.r = a;
            x.e = 1'b1;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            x.q = a;
            x.r = '0;
            x.e = 1'b1;
        end else begin
            x.q = W'(la / lb);
            x.r = W'(la % lb);
            x.e = 1'b0;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start pulse; its sampling edge is "edge 0".
    task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        if (push) sb_q.push_back(model(a, b));
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    // Called right after pulse(): wait for the ready pulse, check latency and results.
    task automatic wait_ready(input string tag);
        int   n;
        exp_t e;
        logic [W-1:0] hq;
        logic         he;
        n = 0;
        while (!data_resultRDY && n < TIMEOUT) begin
            @(negedge clock);
            n++;
            if (n == 1) chk({tag, ".busy_mid"}, 64'(busy), 64'd1);
        end
        chk({tag, ".latency"}, 64'(n), 64'(LAT));
        if (!data_resultRDY) return;
        chk({tag, ".busy_rdy"}, 64'(busy), 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, ".sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".q"}, 64'(data_result), 64'(e.q));
        chk({tag, ".r"}, 64'(data_remainder), 64'(e.r));
        chk({tag, ".exc"}, 64'(data_exception), 64'(e.e));
        hq = data_result;
        he = data_exception;
        @(negedge clock);
        chk({tag, ".rdy_pulse"}, 64'(data_resultRDY), 64'd0);
        chk({tag, ".hold_q"}, 64'(data_result), 64'(hq));
        chk({tag, ".hold_e"}, 64'(data_exception), 64'(he));
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        pulse(a, b, 1'b1);
        wait_ready(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".q0"}, 64'(data_result), 64'd0);
        chk({tag, ".r0"}, 64'(data_remainder), 64'd0);
        chk({tag, ".e0"}, 64'(data_exception), 64'd0);
        chk({tag, ".rdy0"}, 64'(data_resultRDY), 64'd0);
        chk({tag, ".busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;

        op("p100_7", 32'd100, 32'd7);
        op("m100_7", -32'sd100, 32'd7);
        op("p100_m7", 32'd100, -32'sd7);
        op("m100_m7", -32'sd100, -32'sd7);
        op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF);
        op("min_1", 32'h8000_0000, 32'd1);
        op("div0", 32'd55, 32'd0);
        op("after_div0", 32'd9, 32'd3);
        op("small_big", 32'd7, 32'd100);
        op("m1_min", 32'hFFFF_FFFF, 32'h8000_0000);

        // Restart mid-operation: only the second operation reports.
        pulse(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clock);
        pulse(32'd81, 32'd9, 1'b1);
        wait_ready("restart");

        // Reset mid-operation: no ready pulse, everything cleared.
        pulse(32'd1000, 32'd3, 1'b0);
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_zero("abort");
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        chk("abort.no_rdy", 64'(seen), 64'd0);
        op("after_abort", 32'd1000, 32'd3);

        // Reset and start on the same edge: reset wins.
        @(negedge clock);
        reset         = 1'b1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
        @(negedge clock);
        reset    = 1'b0;
        ctrl_DIV = 1'b0;
        check_zero("rst_vs_start");
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) seen++;
        end
        chk("rst_vs_start.no_rdy", 64'(seen), 64'd0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? W'($urandom_range(1, 5000)) : $urandom;
            if (i == 5) rb = -rb;
            op($sformatf("rand%0d", i), ra, rb);
        end

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
